// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

   localparam int unsigned LEN_REG_ADDRESS = 4;
   localparam logic        ENABLE          = 1'b1;
   localparam int unsigned LEN_HZ_STATE    = 2;

   typedef enum logic [LEN_HZ_STATE-1:0] {
      HZ_STATE_RUN      = 2'd0,
      HZ_STATE_MEM_WAIT = 2'd1,
      HZ_STATE_ERROR    = 2'd2
   } hz_state_e;

   // True when a valid ID-stage source names the given destination register.
   function automatic logic src_match(input logic                       vld,
                                      input logic [LEN_REG_ADDRESS-1:0] src,
                                      input logic [LEN_REG_ADDRESS-1:0] dest);
      return vld && (src == dest);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall / bubble / flush sequencing beside the ID stage: data-hazard detection,
// SRAM-wait freeze with timeout watchdog, and stall statistics.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       forwarding_enable,
   input  logic [LEN_REG_ADDRESS-1:0] id_src1,
   input  logic [LEN_REG_ADDRESS-1:0] id_src2,
   input  logic                       id_src1_valid,
   input  logic                       id_src2_valid,
   input  logic                       exe_wb_enable,
   input  logic                       exe_mem_read,
   input  logic [LEN_REG_ADDRESS-1:0] exe_reg_dest,
   input  logic                       mem_wb_enable,
   input  logic [LEN_REG_ADDRESS-1:0] mem_reg_dest,
   input  logic                       mem_req,
   input  logic                       mem_ready,
   input  logic                       branch_taken,
   input  logic                       stats_clear,
   output logic                       hazard_stall,
   output logic                       freeze_pipe,
   output logic                       flush,
   output logic                       mem_timeout,
   output logic [CNT_W-1:0]           hazard_cycles,
   output logic [CNT_W-1:0]           mem_wait_cycles
);

   localparam int unsigned       WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   hz_state_e         state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic hit_exe, hit_mem, raw, mem_busy;

   // RAW detection: with forwarding only load-use stalls, otherwise any pending writer.
   always_comb begin
      hit_exe = src_match(id_src1_valid, id_src1, exe_reg_dest)
              | src_match(id_src2_valid, id_src2, exe_reg_dest);
      hit_mem = src_match(id_src1_valid, id_src1, mem_reg_dest)
              | src_match(id_src2_valid, id_src2, mem_reg_dest);
      if (forwarding_enable == ENABLE) begin
         raw = exe_wb_enable & exe_mem_read & hit_exe;
      end else begin
         raw = (exe_wb_enable & hit_exe) | (mem_wb_enable & hit_mem);
      end
   end

   assign mem_busy = mem_req & ~mem_ready;

   // Memory-wait FSM and watchdog next state.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         HZ_STATE_RUN: begin
            if (mem_busy) begin
               state_d    = HZ_STATE_MEM_WAIT;
               wait_cnt_d = WCNT_W'(1);
            end
         end
         HZ_STATE_MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = HZ_STATE_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WCNT_LAST) begin
               state_d       = HZ_STATE_ERROR;
               mem_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         HZ_STATE_ERROR: begin
            state_d = HZ_STATE_ERROR;
         end
         default: begin
            state_d = HZ_STATE_RUN;
         end
      endcase
   end

   // FSM, wait counter and sticky timeout registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HZ_STATE_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Zero-latency control outputs; priority freeze > flush > stall, all forced low in reset.
   always_comb begin
      freeze_pipe  = rst_n & (((state_q != HZ_STATE_ERROR) & mem_busy)
                              | (state_q == HZ_STATE_ERROR));
      flush        = rst_n & branch_taken & ~freeze_pipe;
      hazard_stall = rst_n & raw & ~branch_taken & ~freeze_pipe;
   end

   assign mem_timeout = mem_timeout_q;

   sat_counter #(.W(CNT_W)) u_hazard_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stats_clear),
      .inc   (hazard_stall),
      .count (hazard_cycles)
   );

   sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stats_clear),
      .inc   (freeze_pipe),
      .count (mem_wait_cycles)
   );

endmodule
